// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package imem_loader_pkg;

  // Loader sequencing states: two header bytes, the data phase, then a
  // terminal success or rejection state that holds until restarted.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } loader_state_t;

  // Number of bytes in the word-count header that precedes the program.
  localparam int unsigned HDR_BYTES = 2;

  // Bytes per instruction word; the stream is little-endian within a word.
  localparam int unsigned BYTES_PER_WORD = 4;

  // True for the states in which the loader is consuming host bytes.
  function automatic logic is_busy_state(input loader_state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == DATA);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes into a little-endian 32-bit word. The first three
// bytes are held in an accumulator; the fourth byte is combined directly
// with it so the completed word is available in the same cycle it arrives.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_b,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] acc_q, acc_d;

  // Next byte index and accumulator contents; clear wins over a byte.
  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (clear_i) begin
      idx_d = '0;
      acc_d = '0;
    end else if (byte_valid_i) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    acc_d[7:0]   = byte_i;
        2'd1:    acc_d[15:8]  = byte_i;
        2'd2:    acc_d[23:16] = byte_i;
        default: acc_d        = '0;
      endcase
    end
  end

  // Byte index and partial word storage, discarded on reset.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

  // A word completes when the most-significant byte is accepted.
  always_comb begin
    word_valid_o = byte_valid_i & ~clear_i & (idx_q == LAST_IDX);
    word_o       = {byte_i, acc_q};
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction loader: receives a length-prefixed byte stream,
// writes packed words sequentially into imem and keeps the CPU in reset
// until the whole program has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH      = 1024,
  parameter int unsigned IMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic                       load_start_i,
  input  logic                       rx_valid_i,
  input  logic [7:0]                 rx_data_i,
  output logic                       rx_ready_o,
  output logic                       wr_en_o,
  output logic [IMEM_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [31:0]                wr_data_o,
  output logic                       cpu_reset_b_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o,
  output logic [15:0]                words_loaded_o
);

  localparam int unsigned HDR_BITS = HDR_BYTES * 8;
  localparam logic [HDR_BITS:0] DEPTH_EXT = (HDR_BITS+1)'(IMEM_DEPTH);

  loader_state_t state_q, state_d;

  logic [HDR_BITS-1:0]        n_q, n_d;
  logic [15:0]                words_loaded_q, words_loaded_d;
  logic                       wr_en_q, wr_en_d;
  logic [IMEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]                wr_data_q, wr_data_d;
  logic                       cpu_reset_b_q, cpu_reset_b_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;

  logic                rx_ready;
  logic                accept;
  logic                data_byte;
  logic                word_valid;
  logic [31:0]         word;
  logic [HDR_BITS-1:0] n_full;
  logic                last_word;

  // Handshake: a byte moves only in a consuming state and never in a
  // restart cycle, so the restart byte is left for the host to re-offer.
  always_comb begin
    rx_ready  = is_busy_state(state_q) & ~load_start_i;
    accept    = rx_valid_i & rx_ready;
    data_byte = accept & (state_q == DATA);
    n_full    = {rx_data_i, n_q[7:0]};
    last_word = (words_loaded_q + 16'd1) == n_q;
  end

  assign rx_ready_o = rx_ready;

  imem_word_packer u_packer (
    .clk          (clk),
    .reset_b      (reset_b),
    .clear_i      (load_start_i),
    .byte_valid_i (data_byte),
    .byte_i       (rx_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Next-state logic for the loader sequence; restart overrides everything.
  always_comb begin
    state_d = state_q;
    if (load_start_i) begin
      state_d = HDR_LO;
    end else begin
      case (state_q)
        IDLE:   state_d = IDLE;
        HDR_LO: if (accept) state_d = HDR_HI;
        HDR_HI: begin
          if (accept) begin
            if (n_full == '0) begin
              state_d = DONE;
            end else if ({1'b0, n_full} > DEPTH_EXT) begin
              state_d = ERROR;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA:   if (word_valid && last_word) state_d = DONE;
        DONE:   state_d = DONE;
        ERROR:  state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  // Header latch, word counter and the registered write port.
  always_comb begin
    n_d            = n_q;
    words_loaded_d = words_loaded_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    if (load_start_i) begin
      n_d            = '0;
      words_loaded_d = '0;
    end else begin
      if (accept && (state_q == HDR_LO)) begin
        n_d[7:0] = rx_data_i;
      end
      if (accept && (state_q == HDR_HI)) begin
        n_d[15:8] = rx_data_i;
      end
      if (word_valid) begin
        wr_en_d        = 1'b1;
        wr_addr_d      = words_loaded_q[IMEM_ADDR_WIDTH-1:0];
        wr_data_d      = word;
        words_loaded_d = words_loaded_q + 16'd1;
      end
    end
  end

  // Status flags follow the next state so they change on the same edge as
  // the state; the CPU is released one edge after DONE is reached so the
  // final imem write has landed before fetch begins.
  always_comb begin
    busy_d        = is_busy_state(state_d);
    done_d        = (state_d == DONE);
    error_d       = (state_d == ERROR);
    cpu_reset_b_d = (state_q == DONE) & ~load_start_i;
  end

  // All loader state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q        <= IDLE;
      n_q            <= '0;
      words_loaded_q <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      cpu_reset_b_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      words_loaded_q <= words_loaded_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      cpu_reset_b_q  <= cpu_reset_b_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign wr_en_o        = wr_en_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign cpu_reset_b_o  = cpu_reset_b_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected imem writes are queued as
// stimulus is issued and a monitor compares every wr_en pulse against them.
module tb_imem_loader;

  logic        clk;
  logic        reset_b;
  logic        load_start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_reset_b;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sbQ[$];
  int  checks   = 0;
  int  failures = 0;

  imem_loader #(
    .IMEM_DEPTH      (1024),
    .IMEM_ADDR_WIDTH (10)
  ) dut (
    .clk            (clk),
    .reset_b        (reset_b),
    .load_start_i   (load_start),
    .rx_valid_i     (rx_valid),
    .rx_data_i      (rx_data),
    .rx_ready_o     (rx_ready),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .wr_data_o      (wr_data),
    .cpu_reset_b_o  (cpu_reset_b),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error),
    .words_loaded_o (words_loaded)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the run ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic pushWrite(input logic [9:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sbQ.push_back(e);
  endtask

  // Monitor: every imem write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write addr=%0d data=0x%08h required=none", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = sbQ.pop_front();
        checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
        checkOutput("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic pulseStart();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  // Offer one byte, optionally after an idle gap, and return just after the
  // edge that accepted it.
  task automatic applyStimulus(input logic [7:0] b, input int maxGap);
    int t;
    if (maxGap > 0) repeat ($urandom_range(1, maxGap)) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) checkOutput("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendHeader(input logic [15:0] n, input int maxGap);
    applyStimulus(n[7:0], maxGap);
    applyStimulus(n[15:8], maxGap);
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxGap);
    for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8], maxGap);
  endtask

  // Called right after the final byte is accepted: done now, CPU one later.
  task automatic checkRelease(input string tag, input logic [15:0] nWords);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_cpurst_held"}, 32'(cpu_reset_b), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_cpurst_rel"}, 32'(cpu_reset_b), 32'd1);
    checkOutput({tag, "_words"}, 32'(words_loaded), 32'(nWords));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic loadThree(input string tag, input int maxGap);
    pushWrite(10'd0, 32'h0000_0013);
    pushWrite(10'd1, 32'h0010_0093);
    pushWrite(10'd2, 32'h0000_0063);
    pulseStart();
    checkOutput({tag, "_start_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_start_cpurst"}, 32'(cpu_reset_b), 32'd0);
    checkOutput({tag, "_start_done"}, 32'(done), 32'd0);
    sendHeader(16'd3, maxGap);
    sendWord(32'h0000_0013, maxGap);
    sendWord(32'h0010_0093, maxGap);
    sendWord(32'h0000_0063, maxGap);
    checkRelease(tag, 16'd3);
  endtask

  initial begin
    logic [31:0] w;
    reset_b    = 1'b0;
    load_start = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    #2;
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", wr_data, 32'd0);
    checkOutput("rst_cpu_reset_b", 32'(cpu_reset_b), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_rx_ready", 32'(rx_ready), 32'd0);

    $display("[TB] three-word load");
    loadThree("load3", 0);

    $display("[TB] empty load");
    pulseStart();
    checkOutput("empty_restart_cpurst", 32'(cpu_reset_b), 32'd0);
    checkOutput("empty_restart_done", 32'(done), 32'd0);
    sendHeader(16'd0, 0);
    checkRelease("empty", 16'd0);

    $display("[TB] oversize header");
    pulseStart();
    sendHeader(16'd1025, 0);
    checkOutput("over_error", 32'(error), 32'd1);
    checkOutput("over_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("over_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("over_cpurst", 32'(cpu_reset_b), 32'd0);
    checkOutput("over_done", 32'(done), 32'd0);

    $display("[TB] full-depth load");
    for (int i = 0; i < 1024; i++) pushWrite(10'(i), (32'(i) * 32'h0101_0101) ^ 32'h1234_5678);
    pulseStart();
    checkOutput("full_error_clr", 32'(error), 32'd0);
    sendHeader(16'd1024, 0);
    checkOutput("full_busy", 32'(busy), 32'd1);
    checkOutput("full_error", 32'(error), 32'd0);
    for (int i = 0; i < 1024; i++) begin
      w = (32'(i) * 32'h0101_0101) ^ 32'h1234_5678;
      sendWord(w, 0);
    end
    checkRelease("full", 16'd1024);

    $display("[TB] load with gaps");
    loadThree("gaps", 3);

    $display("[TB] restart mid-load");
    pulseStart();
    sendHeader(16'd3, 0);
    applyStimulus(8'h13, 0);
    applyStimulus(8'h00, 0);
    @(negedge clk);
    load_start = 1'b1;
    rx_valid   = 1'b1;
    rx_data    = 8'hEE;
    #1;
    checkOutput("restart_rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    load_start = 1'b0;
    rx_valid   = 1'b0;
    checkOutput("restart_words", 32'(words_loaded), 32'd0);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    checkOutput("restart_cpurst", 32'(cpu_reset_b), 32'd0);
    pushWrite(10'd0, 32'hDEAD_BEEF);
    sendHeader(16'd1, 0);
    sendWord(32'hDEAD_BEEF, 0);
    checkRelease("restart", 16'd1);

    $display("[TB] async reset mid-data");
    pulseStart();
    sendHeader(16'd2, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0);
    @(posedge clk);
    #3;
    reset_b = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_words", 32'(words_loaded), 32'd0);
    checkOutput("arst_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("arst_wr_data", wr_data, 32'd0);
    checkOutput("arst_cpurst", 32'(cpu_reset_b), 32'd0);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    repeat (5) @(negedge clk);
    checkOutput("arst_idle_ready", 32'(rx_ready), 32'd0);
    checkOutput("arst_idle_words", 32'(words_loaded), 32'd0);
    checkOutput("arst_idle_done", 32'(done), 32'd0);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
